// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx : 8N1 asynchronous serial receiver, LSB first, idle-high line.
//
// Receive-side partner of uart_tx. It uses the same bit period and framing.
// Each correctly framed byte appears on o_data together with a one-cycle
// o_valid strobe. A zero stop bit gives a one-cycle o_frame_err strobe
// instead, and the receiver then waits for the line to return high.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (>= 4). 104 = 12 MHz / 115200.
//
// Ports
//   i_clock      : sole clock
//   i_reset      : synchronous, active-high reset
//   i_rx         : serial line, asynchronous to i_clock, idles at 1
//   o_data[7:0]  : last correctly framed byte; held between frames
//   o_valid      : one-cycle pulse, o_data is new in the same cycle
//   o_frame_err  : one-cycle pulse, the stop bit was sampled as 0
//   o_busy       : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_busy
);

   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   // Synchronizer stage. The flops reset to 1 so that reset looks like an idle line.
   logic [1:0] sync_q;
   logic       rxs;

   // Control state
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [2:0]       idx_q,   idx_d;
   logic             valid_q, valid_d;
   logic             ferr_q,  ferr_d;
   logic [7:0]       data_q,  data_d;

   // Datapath: shift register. Every bit is rewritten in each frame, so it needs no reset.
   logic [7:0]       shift_q, shift_d;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], i_rx};
      end
   end

   assign rxs = sync_q[1];

   // State and output registers
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         data_q  <= data_d;
      end
   end

   always_ff @(posedge i_clock) begin
      shift_q <= shift_d;
   end

   // Next-state logic. The counter runs freely inside a state. It is cleared on
   // every state change and at every bit boundary inside DATA.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rxs) begin
               state_d = S_START;
            end
         end

         // Re-check the start bit at its centre. A line that is high again by
         // then was only a glitch, so the frame is dropped without any pulse.
         S_START: begin
            if (cnt_q == CNT_HALF_LAST) begin
               cnt_d = '0;
               if (!rxs) begin
                  state_d = S_DATA;
                  idx_d   = 3'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         // The counter was aligned to mid-bit in START. Each full period
         // therefore lands on the centre of the next data bit.
         S_DATA: begin
            if (cnt_q == CNT_BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rxs;
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end

         // Leave at mid-stop-bit. This gives IDLE half a bit of margin to see
         // a start bit that immediately follows this one.
         S_STOP: begin
            if (cnt_q == CNT_BIT_LAST) begin
               cnt_d = '0;
               if (rxs) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end

         // The line is held low (break, or wrong baud rate). Waiting for it to
         // go high keeps the receiver from reading garbage frames.
         S_BREAK: begin
            cnt_d = '0;
            if (rxs) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_frame_err = ferr_q;
   assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx : directed testbench for uart_rx with CLKS_PER_BIT = 16.
// The bench drives a bit-accurate serial line model. A negedge monitor
// records every o_valid byte and the edge number where it appears. It also
// counts o_frame_err and o_busy cycles.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ferr;
   logic       busy;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_rx       (rx),
      .o_data     (data),
      .o_valid    (valid),
      .o_frame_err(ferr),
      .o_busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor
   logic [7:0] vq[$];
   int         vt[$];
   int         fe_cnt   = 0;
   int         busy_cnt = 0;
   int         both_cnt = 0;

   always @(negedge clk) begin
      if (valid) begin
         vq.push_back(data);
         vt.push_back(cyc);
      end
      if (ferr)          fe_cnt   = fe_cnt + 1;
      if (busy)          busy_cnt = busy_cnt + 1;
      if (valid && ferr) both_cnt = both_cnt + 1;
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Call this after a posedge (posedge + #1). It leaves the bench at posedge + #1.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Frame model: start bit, 8 data bits LSB first, stop bit. Each bit lasts CPB cycles.
   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop;
      tick(CPB);
   endtask

   typedef struct {
      logic [7:0] tx;
      logic       stop;
      int         exp_nvalid;
      logic [7:0] exp_data;
      int         exp_ferr;
   } vec_t;

   vec_t  tbl[6];
   string msg;
   int    v0, f0, b0, t0;

   initial begin
      tbl[0] = '{tx: 8'h00, stop: 1'b1, exp_nvalid: 1, exp_data: 8'h00, exp_ferr: 0};
      tbl[1] = '{tx: 8'hFF, stop: 1'b1, exp_nvalid: 1, exp_data: 8'hFF, exp_ferr: 0};
      tbl[2] = '{tx: 8'h81, stop: 1'b1, exp_nvalid: 1, exp_data: 8'h81, exp_ferr: 0};
      tbl[3] = '{tx: 8'h3C, stop: 1'b0, exp_nvalid: 0, exp_data: 8'h81, exp_ferr: 1};
      tbl[4] = '{tx: 8'h7E, stop: 1'b1, exp_nvalid: 1, exp_data: 8'h7E, exp_ferr: 0};
      tbl[5] = '{tx: 8'hA5, stop: 1'b1, exp_nvalid: 1, exp_data: 8'hA5, exp_ferr: 0};

      // Reset state
      rst = 1'b1;
      rx  = 1'b1;
      tick(3);
      chk("reset_data",  int'(data),  8'h00);
      chk("reset_valid", int'(valid), 0);
      chk("reset_ferr",  int'(ferr),  0);
      chk("reset_busy",  int'(busy),  0);
      rst = 1'b0;
      tick(2);

      // Clean frame 0x55 with exact latency
      v0 = vq.size();
      f0 = fe_cnt;
      t0 = cyc + 1;
      send_byte(8'h55, 1'b1);
      rx = 1'b1;
      tick(4);
      chk("clean_nvalid", vq.size() - v0, 1);
      if (vq.size() > v0) begin
         chk("clean_edge", vt[v0] - t0, 2 + 8 + 9 * CPB);
         chk("clean_data", int'(vq[v0]), 8'h55);
      end
      chk("clean_ferr", fe_cnt - f0, 0);
      chk("clean_busy_after", int'(busy), 0);

      // Table of frames
      for (int i = 0; i < 6; i++) begin
         v0 = vq.size();
         f0 = fe_cnt;
         send_byte(tbl[i].tx, tbl[i].stop);
         rx = 1'b1;
         tick(20);
         $sformat(msg, "vec%0d", i);
         chk({msg, "_nvalid"}, vq.size() - v0, tbl[i].exp_nvalid);
         chk({msg, "_ferr"}, fe_cnt - f0, tbl[i].exp_ferr);
         chk({msg, "_data"}, int'(data), int'(tbl[i].exp_data));
         chk({msg, "_idle"}, int'(busy), 0);
      end

      // Back-to-back frames with no idle gap
      v0 = vq.size();
      send_byte(8'h48, 1'b1);
      send_byte(8'h65, 1'b1);
      rx = 1'b1;
      tick(10);
      chk("b2b_nvalid", vq.size() - v0, 2);
      if (vq.size() >= v0 + 2) begin
         chk("b2b_spacing", vt[v0+1] - vt[v0], 10 * CPB);
         chk("b2b_data0", int'(vq[v0]), 8'h48);
         chk("b2b_data1", int'(vq[v0+1]), 8'h65);
      end

      // Start-bit glitch
      v0 = vq.size();
      f0 = fe_cnt;
      b0 = busy_cnt;
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(30);
      chk("glitch_busy_1to8", int'((busy_cnt - b0) >= 1 && (busy_cnt - b0) <= 8), 1);
      chk("glitch_idle", int'(busy), 0);
      chk("glitch_nvalid", vq.size() - v0, 0);
      chk("glitch_ferr", fe_cnt - f0, 0);
      chk("glitch_data", int'(data), 8'h65);

      // Framing error followed by a held-low line
      v0 = vq.size();
      f0 = fe_cnt;
      send_byte(8'h12, 1'b1);
      send_byte(8'hA5, 1'b0);
      tick(3 * CPB);
      chk("ferr_busy_low_line", int'(busy), 1);
      rx = 1'b1;
      tick(2);
      chk("ferr_busy_rise_plus1", int'(busy), 1);
      tick(1);
      chk("ferr_busy_rise_plus2", int'(busy), 0);
      chk("ferr_nvalid", vq.size() - v0, 1);
      chk("ferr_count", fe_cnt - f0, 1);
      chk("ferr_data_held", int'(data), 8'h12);
      tick(5);

      // Reset during data bit 3 of an 0xFF frame
      v0 = vq.size();
      f0 = fe_cnt;
      rx = 1'b0;
      tick(CPB);
      rx = 1'b1;
      tick(3 * CPB + CPB / 2);
      chk("rstmid_busy_before", int'(busy), 1);
      rst = 1'b1;
      tick(1);
      chk("rstmid_data", int'(data), 8'h00);
      chk("rstmid_valid", int'(valid), 0);
      chk("rstmid_ferr", int'(ferr), 0);
      chk("rstmid_busy", int'(busy), 0);
      rst = 1'b0;
      tick(7 * CPB);
      chk("rstmid_no_pulse_valid", vq.size() - v0, 0);
      chk("rstmid_no_pulse_ferr", fe_cnt - f0, 0);
      send_byte(8'h0F, 1'b1);
      rx = 1'b1;
      tick(4);
      chk("rstmid_next_nvalid", vq.size() - v0, 1);
      chk("rstmid_next_data", int'(data), 8'h0F);

      // Streamed message, back-to-back
      msg = "Hello World!\n";
      v0  = vq.size();
      f0  = fe_cnt;
      for (int i = 0; i < msg.len(); i++) begin
         send_byte(msg[i], 1'b1);
      end
      rx = 1'b1;
      tick(20);
      chk("stream_nvalid", vq.size() - v0, 13);
      chk("stream_ferr", fe_cnt - f0, 0);
      if (vq.size() >= v0 + 13) begin
         for (int i = 0; i < 13; i++) begin
            chk("stream_byte", int'(vq[v0+i]), int'(msg[i]));
         end
      end

      chk("valid_ferr_exclusive", both_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
